// File: rtl/mem_arbiter_n.sv
// rtl/mem_arbiter_n.sv - N-channel cache-line memory arbiter; MEM_ARB_ROUND_ROBIN_EN selects round-robin, else highest-index fixed priority
module mem_arbiter_n #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128,
    localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_read,
    input  logic [NUM_CH-1:0]        req_write,
    input  logic [NUM_CH*ADDR_W-1:0] req_address,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        req_resp,
    output logic [DATA_W-1:0]        req_rdata,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_resp,
    output logic                     grant_valid,
    output logic [ID_W-1:0]          grant_id
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [ID_W-1:0]     lat_id;
    logic                lat_wr;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [NUM_CH-1:0]   req_any;
    logic [ID_W-1:0]     win_id;
    logic                active;

    assign req_any = req_read | req_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr;

    // winner is the first requester at or after the pointer, wrapping around
    always_comb begin
        int   j;
        logic found;
        win_id = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!found && req_any[j]) begin
                found  = 1'b1;
                win_id = ID_W'(j);
            end
        end
    end

    // pointer moves past the channel whose transaction just completed
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (state == BUSY && mem_resp) begin
            ptr <= (lat_id == ID_W'(NUM_CH - 1)) ? '0 : lat_id + 1'b1;
        end
    end
`else
    // fixed priority: the highest-indexed requester wins
    always_comb begin
        win_id = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_any[i]) win_id = ID_W'(i);
        end
    end
`endif

    // IDLE/BUSY control: latch the winner's transaction, release on mem_resp
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lat_id    <= '0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_any) begin
                        lat_id    <= win_id;
                        lat_wr    <= req_write[win_id];
                        lat_addr  <= req_address[win_id*ADDR_W +: ADDR_W];
                        lat_wdata <= req_wdata[win_id*DATA_W +: DATA_W];
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_resp) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // outputs follow the latched transaction; reset masks a completion in flight
    always_comb begin
        active      = (state == BUSY) && !reset;
        mem_read    = active && !lat_wr;
        mem_write   = active && lat_wr;
        mem_address = lat_addr;
        mem_wdata   = lat_wdata;
        grant_valid = active;
        grant_id    = active ? lat_id : '0;
        req_rdata   = mem_rdata;
        req_resp    = '0;
        if (active && mem_resp) req_resp[lat_id] = 1'b1;
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb/tb_mem_arbiter_n.sv - randomized self-checking bench for mem_arbiter_n against a transaction-level model
module tb_mem_arbiter_n;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 128;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_read, req_write, req_resp;
    logic [N*AW-1:0] req_address;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   req_rdata, mem_wdata, mem_rdata;
    logic            mem_read, mem_write, mem_resp, grant_valid;
    logic [AW-1:0]   mem_address;
    logic [IW-1:0]   grant_id;

    always #5 clk = ~clk;

    mem_arbiter_n #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_resp(req_resp), .req_rdata(req_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // transaction-level model: who owns the memory port and what they asked for
    bit            m_busy;
    int            m_id;
    int            m_ptr;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [N-1:0]  e_resp;

    function automatic int pick(input logic [N-1:0] any, input int ptr);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) begin
            if (any[(ptr + k) % N]) return (ptr + k) % N;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (any[i]) return i;
        end
`endif
        return -1;
    endfunction

    // compare this cycle's outputs with the model, advance the model, move to the next cycle
    task automatic step();
        bit act;
        int w;
        #1;
        act    = m_busy && !reset;
        e_resp = '0;
        if (act && mem_resp) e_resp[m_id] = 1'b1;
        check("mem_read", mem_read, act && !m_wr);
        check("mem_write", mem_write, act && m_wr);
        check("grant_valid", grant_valid, act);
        check("grant_id", grant_id, act ? m_id : 0);
        check("req_resp", req_resp, e_resp);
        check("req_rdata", req_rdata, mem_rdata);
        if (act) begin
            check("mem_address", mem_address, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
        end
        if (reset) begin
            m_busy = 0;
            m_ptr  = 0;
        end else if (m_busy) begin
            if (mem_resp) begin
                m_busy = 0;
                m_ptr  = (m_id + 1) % N;
            end
        end else begin
            w = pick(req_read | req_write, m_ptr);
            if (w >= 0) begin
                m_busy  = 1;
                m_id    = w;
                m_wr    = req_write[w];
                m_addr  = req_address[w*AW +: AW];
                m_wdata = req_wdata[w*DW +: DW];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_read  = '0;
        req_write = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        mem_resp = 1'b0;
        step();
        reset = 1'b0;
    endtask

    int exp_order[5];
    int first_ch, second_ch;

    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
        first_ch  = 0;
        second_ch = 1;
`else
        exp_order = '{3, 3, 3, 3, 3};
        first_ch  = 1;
        second_ch = 0;
`endif
        reset = 1'b1;
        clear_reqs();
        req_address = '0;
        req_wdata   = '0;
        mem_rdata   = '0;
        mem_resp    = 1'b0;
        m_busy = 0; m_id = 0; m_ptr = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
        @(posedge clk);
        #1;
        step();
        check("rst_grant_valid", grant_valid, 1'b0);
        check("rst_grant_id", grant_id, 0);
        reset = 1'b0;

        // single read on channel 0
        req_read[0] = 1'b1;
        req_address[0*AW +: AW] = 16'h1230;
        step();
        check("d_read_strobe", mem_read, 1'b1);
        check("d_read_addr", mem_address, 16'h1230);
        mem_resp  = 1'b1;
        mem_rdata = {16{8'hAA}};
        #1;
        check("d_read_resp", req_resp, 4'b0001);
        check("d_read_rdata", req_rdata, {16{8'hAA}});
        step();
        mem_resp = 1'b0;
        clear_reqs();
        step();

        // read+write together on channel 1 is a write
        req_read[1]  = 1'b1;
        req_write[1] = 1'b1;
        req_wdata[1*DW +: DW] = {16{8'h55}};
        step();
        check("d_rw_write", mem_write, 1'b1);
        check("d_rw_read", mem_read, 1'b0);
        check("d_rw_wdata", mem_wdata, {16{8'h55}});
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        clear_reqs();

        // stray mem_resp while idle
        mem_resp = 1'b1;
        step();
        check("d_idle_resp_gv", grant_valid, 1'b0);
        mem_resp = 1'b0;
        step();

        // channels 0 and 1 contend
        do_reset();
        req_read[1:0] = 2'b11;
        step();
        check("d_cont_first", grant_id, first_ch);
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        req_read[first_ch] = 1'b0;
        step();
        check("d_cont_second", grant_id, second_ch);
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        clear_reqs();

        // all four continuously requesting
        do_reset();
        req_read = '1;
        for (int g = 0; g < 5; g++) begin
            step();
            check("d_all_gv", grant_valid, 1'b1);
            check("d_all_order", grant_id, exp_order[g]);
            mem_resp = 1'b1;
            step();
            mem_resp = 1'b0;
            check("d_all_gap", grant_valid, 1'b0);
        end
        clear_reqs();
        step();

        // reset during BUSY together with mem_resp
        req_write[2] = 1'b1;
        step();
        reset    = 1'b1;
        mem_resp = 1'b1;
        #1;
        check("d_rstbusy_resp", req_resp, 4'b0000);
        check("d_rstbusy_wr", mem_write, 1'b0);
        step();
        reset    = 1'b0;
        mem_resp = 1'b0;
        check("d_rstbusy_after_gv", grant_valid, 1'b0);
        check("d_rstbusy_after_wr", mem_write, 1'b0);
        req_read = '1;
        clear_reqs();
        req_read = '1;
        step();
        check("d_rstbusy_ptr", grant_id, exp_order[0]);
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        clear_reqs();
        step();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom % 64) == 0;
            mem_resp  = ($urandom % 3) == 0;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            step();
            for (int i = 0; i < N; i++) begin
                if (e_resp[i]) begin
                    req_read[i]  = 1'b0;
                    req_write[i] = 1'b0;
                end else if (!(req_read[i] || req_write[i])) begin
                    if (($urandom % 4) == 0) begin
                        case ($urandom % 3)
                            0: begin req_read[i] = 1'b1; req_write[i] = 1'b0; end
                            1: begin req_read[i] = 1'b0; req_write[i] = 1'b1; end
                            default: begin req_read[i] = 1'b1; req_write[i] = 1'b1; end
                        endcase
                        req_address[i*AW +: AW] = AW'($urandom);
                        req_wdata[i*DW +: DW]   = {$urandom, $urandom, $urandom, $urandom};
                    end
                end else if (($urandom % 25) == 0) begin
                    req_read[i]  = 1'b0;
                    req_write[i] = 1'b0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_n.md
MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

Interface
REQ-001 Parameter NUM_CH, default 2, number of requester channels (2..8).
REQ-002 Parameter ADDR_W, default 16, address width in bits.
REQ-003 Parameter DATA_W, default 128, cache-line data width in bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_read  input  NUM_CH  per-channel line read request, level, held until req_resp.
REQ-007 req_write  input  NUM_CH  per-channel line write request, level, held until req_resp.
REQ-008 req_address  input  NUM_CH*ADDR_W  channel i address in bits [i*ADDR_W +: ADDR_W].
REQ-009 req_wdata  input  NUM_CH*DATA_W  channel i write line in bits [i*DATA_W +: DATA_W].
REQ-010 req_resp  output  NUM_CH  one-hot completion pulse to the granted channel.
REQ-011 req_rdata  output  DATA_W  read line broadcast to all channels, valid with req_resp.
REQ-012 mem_read / mem_write  output  1 each  downstream request strobes, level.
REQ-013 mem_address  output  ADDR_W  downstream address.
REQ-014 mem_wdata  output  DATA_W  downstream write line.
REQ-015 mem_rdata  input  DATA_W  downstream read line.
REQ-016 mem_resp  input  1  downstream completion, one cycle.
REQ-017 grant_valid  output  1 and grant_id  output  $clog2(NUM_CH) (min 1): current owner, for debug and performance counters.

Function
REQ-018 FSM has two states: IDLE and BUSY.
REQ-019 IDLE: if any channel has req_read or req_write asserted, select one winner, latch its index, op type, address and wdata, and enter BUSY on the next edge.
REQ-020 IDLE with no requests: remain IDLE; mem_read, mem_write and req_resp are 0.
REQ-021 BUSY: drive mem_address and mem_wdata from the latched values, and drive mem_read/mem_write from the latched op; grant_valid=1 and grant_id=latched index.
REQ-022 BUSY with mem_resp=1: assert req_resp[grant_id] combinationally in the same cycle, pass mem_rdata through to req_rdata, and return to IDLE on the next edge.
REQ-023 After a response the arbiter spends at least one IDLE cycle before the next grant, giving requesters a cycle to deassert.
REQ-024 Latency: request seen in IDLE at cycle N; mem strobe asserted at cycle N+1; req_resp in the same cycle as mem_resp.
REQ-025 Channel asserting both req_read and req_write: treated as a write; mem_read stays 0.
REQ-026 Requester deasserting before req_resp: ignored; the latched transaction completes and req_resp still pulses.
REQ-027 mem_resp in IDLE: ignored; no req_resp is generated.
REQ-028 req_rdata is mem_rdata unconditionally; requesters qualify it with req_resp.
REQ-029 mem_read and mem_write are never asserted simultaneously.

Reset
REQ-030 On reset: state=IDLE, latched index/op/address/wdata=0, and round-robin pointer=0.
REQ-031 During and after reset until the next grant: mem_read=0, mem_write=0, req_resp=0, grant_valid=0, and grant_id=0.
REQ-032 Reset asserted in BUSY aborts the transaction; a mem_resp in the reset cycle is not forwarded.

Configuration
REQ-033 Macro MEM_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-034 With MEM_ARB_ROUND_ROBIN_EN defined: the winner is the first requesting channel at or after the pointer, modulo NUM_CH; on each completed transaction the pointer becomes the granted index+1, wrapping from NUM_CH-1 to 0.
REQ-035 Without MEM_ARB_ROUND_ROBIN_EN: fixed priority where the highest-indexed requester wins (channel NUM_CH-1 highest, so the D-cache placed at index 1 beats the I-cache at index 0); the pointer logic is absent.

Verification
REQ-036 NUM_CH=2; ch0 read at 0x1230 alone -> cycle+1 mem_read=1, mem_address=0x1230; mem_resp with rdata=0xAA..AA -> req_resp=2'b01, req_rdata=0xAA..AA.
REQ-037 Round-robin on, NUM_CH=4, all four requesting continuously -> grant order 0,1,2,3,0, each separated by one IDLE cycle.
REQ-038 Round-robin off, ch0 and ch1 requesting together -> ch1 granted first, then ch0.
REQ-039 ch1 with read and write both asserted, wdata=0x5555..55 -> mem_write=1, mem_read=0, mem_wdata=0x5555..55.
REQ-040 Reset asserted in BUSY together with mem_resp -> req_resp=0 and all strobes 0 in the next cycle; pointer=0.
REQ-041 mem_resp pulsed while IDLE -> req_resp stays 0 and the state is unchanged.
